// File: rtl/in_wrapper_pkg.sv
// rtl/in_wrapper_pkg.sv - shared state encoding and index-width helper for the input wrapper
package in_wrapper_pkg;

  // Controller state encoding
  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_LOAD  = 3'd1;
  localparam logic [2:0] ENC_CHECK = 3'd2;
  localparam logic [2:0] ENC_START = 3'd3;
  localparam logic [2:0] ENC_WAIT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ENC_IDLE,
    LOAD  = ENC_LOAD,
    CHECK = ENC_CHECK,
    START = ENC_START,
    WAIT  = ENC_WAIT
  } state_t;

  // Width of an operand index; never narrower than one bit
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/in_wrapper_nop_if.sv
// rtl/in_wrapper_nop_if.sv - producer handshake and FP-unit hand-off signals of the input wrapper
interface in_wrapper_nop_if
  import in_wrapper_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2
);
  localparam int IDX_W = idxWidth(NUM_OPS);

  logic                       inReady;
  logic [WIDTH-1:0]           inData;
  logic                       inAccept;
  logic [IDX_W-1:0]           opIdx;
  logic [NUM_OPS*WIDTH-1:0]   ops;
  logic                       startFP;
  logic                       fpDone;
  logic                       busy;

  // Environment side: producer plus FP unit
  modport master (
    output inReady, inData, fpDone,
    input  inAccept, opIdx, ops, startFP, busy
  );

  // Wrapper side
  modport slave (
    input  inReady, inData, fpDone,
    output inAccept, opIdx, ops, startFP, busy
  );

endinterface

// File: rtl/in_operand_bank.sv
// rtl/in_operand_bank.sv - register bank holding one batch of operands
module in_operand_bank
  import in_wrapper_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 2,
  localparam int IDX_W  = idxWidth(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld,
  input  logic [IDX_W-1:0]         idx,
  input  logic [WIDTH-1:0]         d,
  output logic [NUM_OPS*WIDTH-1:0] ops
);

  logic [WIDTH-1:0] slot [NUM_OPS];

  // Write the addressed slot on ld; clear everything on reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_OPS; k++) begin
      if (!rst) begin
        slot[k] <= '0;
      end else if (ld && (idx == IDX_W'(k))) begin
        slot[k] <= d;
      end
    end
  end

  // Flatten slots so slot k sits at bits [k*WIDTH +: WIDTH]
  always_comb begin
    ops = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      ops[k*WIDTH +: WIDTH] = slot[k];
    end
  end

endmodule

// File: rtl/in_wrapper_nop.sv
// rtl/in_wrapper_nop.sv - collects NUM_OPS operands over a four-phase handshake and starts the FP unit
module in_wrapper_nop
  import in_wrapper_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_OPS   = 2,
  parameter bit WAIT_DONE = 1'b1
) (
  input logic              clk,
  input logic              rst,
  in_wrapper_nop_if.slave  bus
);

  localparam int IDX_W = idxWidth(NUM_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t           state, nextState;
  logic [IDX_W-1:0] opIdx, nextIdx;
  logic             ld;
  logic             accept;
  logic             start;
  logic             busyInt;

  // State and operand index registers; reset drops any partial batch
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      opIdx <= '0;
    end else begin
      state <= nextState;
      opIdx <= nextIdx;
    end
  end

  // Next-state and index update; the index only advances once the producer releases inReady
  always_comb begin
    nextState = state;
    nextIdx   = opIdx;
    unique case (state)
      IDLE: begin
        if (bus.inReady) nextState = LOAD;
      end
      LOAD: begin
        nextState = CHECK;
      end
      CHECK: begin
        if (!bus.inReady) begin
          if (opIdx == LAST_IDX) begin
            nextState = START;
          end else begin
            nextIdx   = opIdx + IDX_W'(1);
            nextState = IDLE;
          end
        end
      end
      START: begin
        if (WAIT_DONE) begin
          nextState = WAIT;
        end else begin
          nextState = IDLE;
          nextIdx   = '0;
        end
      end
      WAIT: begin
        if (bus.fpDone) begin
          nextState = IDLE;
          nextIdx   = '0;
        end
      end
      default: begin
        nextState = IDLE;
        nextIdx   = '0;
      end
    endcase
  end

  // Moore outputs decoded purely from state
  always_comb begin
    ld      = 1'b0;
    accept  = 1'b0;
    start   = 1'b0;
    busyInt = 1'b0;
    unique case (state)
      LOAD:  ld      = 1'b1;
      CHECK: accept  = 1'b1;
      START: begin
        start   = 1'b1;
        busyInt = 1'b1;
      end
      WAIT:  busyInt = 1'b1;
      default: ;
    endcase
  end

  assign bus.inAccept = accept;
  assign bus.startFP  = start;
  assign bus.busy     = busyInt;
  assign bus.opIdx    = opIdx;

  in_operand_bank #(
    .WIDTH   (WIDTH),
    .NUM_OPS (NUM_OPS)
  ) uBank (
    .clk (clk),
    .rst (rst),
    .ld  (ld),
    .idx (opIdx),
    .d   (bus.inData),
    .ops (bus.ops)
  );

endmodule

// File: tb/tb_in_wrapper_nop.sv
// tb/tb_in_wrapper_nop.sv - directed self-checking bench for in_wrapper_nop
module tb_in_wrapper_nop;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;

  in_wrapper_nop_if #(.WIDTH(8), .NUM_OPS(3)) a ();
  in_wrapper_nop_if #(.WIDTH(8), .NUM_OPS(2)) b ();

  in_wrapper_nop #(.WIDTH(8), .NUM_OPS(3), .WAIT_DONE(1'b1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  in_wrapper_nop #(.WIDTH(8), .NUM_OPS(2), .WAIT_DONE(1'b0)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One four-phase transfer; leaves the DUT one cycle after the inReady fall is sampled
  task automatic sendOp(input bit useB, input logic [7:0] d);
    if (useB) begin b.inReady = 1'b1; b.inData = d; end
    else      begin a.inReady = 1'b1; a.inData = d; end
    tick();
    chk("load_no_accept", useB ? b.inAccept : a.inAccept, 0);
    tick();
    chk("check_accept", useB ? b.inAccept : a.inAccept, 1);
    if (useB) b.inReady = 1'b0;
    else      a.inReady = 1'b0;
    tick();
    chk("released_accept", useB ? b.inAccept : a.inAccept, 0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    a.inReady = 1'b0; a.inData = '0; a.fpDone = 1'b0;
    b.inReady = 1'b0; b.inData = '0; b.fpDone = 1'b0;

    // Reset dominates a held inReady
    rst = 1'b0;
    a.inReady = 1'b1;
    tick();
    tick();
    chk("rst_accept", a.inAccept, 0);
    chk("rst_start", a.startFP, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_idx", a.opIdx, 0);
    chk("rst_ops", a.ops, 24'h0);
    rst = 1'b1;
    a.inReady = 1'b0;
    tick();
    chk("idle_accept", a.inAccept, 0);

    // Full batch
    sendOp(1'b0, 8'hA1);
    chk("idx_after_1", a.opIdx, 1);
    chk("busy_after_1", a.busy, 0);
    sendOp(1'b0, 8'hB2);
    chk("idx_after_2", a.opIdx, 2);
    sendOp(1'b0, 8'hC3);
    chk("start_pulse", a.startFP, 1);
    chk("start_busy", a.busy, 1);
    chk("batch_ops", a.ops, 24'hC3B2A1);
    chk("start_idx", a.opIdx, 2);
    tick();
    chk("wait_start_low", a.startFP, 0);
    chk("wait_busy", a.busy, 1);
    tick();
    tick();
    chk("wait_busy_later", a.busy, 1);

    // Hold-off: producer ignored while waiting for fpDone
    a.inReady = 1'b1;
    a.inData  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("holdoff_accept", a.inAccept, 0);
      chk("holdoff_ops", a.ops, 24'hC3B2A1);
      chk("holdoff_busy", a.busy, 1);
    end
    a.fpDone = 1'b1;
    tick();
    a.fpDone = 1'b0;
    chk("done_busy", a.busy, 0);
    chk("done_idx", a.opIdx, 0);
    tick();
    chk("reload_no_accept", a.inAccept, 0);
    tick();
    chk("reload_accept", a.inAccept, 1);
    chk("reload_ops", a.ops, 24'hC3B255);
    a.inReady = 1'b0;
    tick();
    chk("reload_idx", a.opIdx, 1);

    // fpDone outside WAIT has no effect
    a.fpDone = 1'b1;
    tick();
    a.fpDone = 1'b0;
    chk("stray_done_idx", a.opIdx, 1);
    chk("stray_done_busy", a.busy, 0);

    // Long hold in CHECK with inData changing
    a.inReady = 1'b1;
    a.inData  = 8'h66;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("hold_accept", a.inAccept, 1);
      chk("hold_idx", a.opIdx, 1);
      chk("hold_ops", a.ops, 24'hC36655);
      a.inData = 8'h70 + 8'(i);
      if (i < 3) tick();
    end
    a.inReady = 1'b0;
    tick();
    chk("hold_release_accept", a.inAccept, 0);
    chk("hold_release_idx", a.opIdx, 2);
    chk("hold_release_ops", a.ops, 24'hC36655);

    // Mid-batch reset after two operands
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_idx", a.opIdx, 0);
    chk("midrst_ops", a.ops, 24'h0);
    chk("midrst_busy", a.busy, 0);
    sendOp(1'b0, 8'h01);
    sendOp(1'b0, 8'h02);
    sendOp(1'b0, 8'h03);
    chk("midrst_start", a.startFP, 1);
    chk("midrst_batch", a.ops, 24'h030201);
    tick();
    a.fpDone = 1'b1;
    tick();
    a.fpDone = 1'b0;
    chk("midrst_done_busy", a.busy, 0);
    chk("midrst_done_idx", a.opIdx, 0);

    // No-wait variant: two back-to-back batches
    sendOp(1'b1, 8'h11);
    chk("nw_idx_1", b.opIdx, 1);
    chk("nw_no_start", b.startFP, 0);
    sendOp(1'b1, 8'h22);
    chk("nw_start_1", b.startFP, 1);
    chk("nw_busy_1", b.busy, 1);
    chk("nw_ops_1", b.ops, 16'h2211);
    tick();
    chk("nw_start_1_low", b.startFP, 0);
    chk("nw_busy_1_low", b.busy, 0);
    chk("nw_idx_reset", b.opIdx, 0);
    sendOp(1'b1, 8'h33);
    sendOp(1'b1, 8'h44);
    chk("nw_start_2", b.startFP, 1);
    chk("nw_busy_2", b.busy, 1);
    chk("nw_ops_2", b.ops, 16'h4433);
    tick();
    chk("nw_start_2_low", b.startFP, 0);
    chk("nw_busy_2_low", b.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
